// File: rtl/sram_ctrl.sv
// Load/store controller for a word-line/byte-lane SRAM array.
// Handles byte, halfword and word accesses; misaligned or illegal sizes answer with an error.
module sram_ctrl #(
   parameter int ROWS   = 16,
   parameter int ADDR_W = $clog2(ROWS) + 2
) (
   input  logic              clk,
   input  logic              rst,
   // Both channels use valid/ready: a transfer happens on a rising edge where valid && ready,
   // and the sender holds its fields steady while valid is high and ready is low.
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ROWS-1:0]   sram_wl,
   output logic [3:0]        sram_write_enable,
   output logic              sram_read_enable,
   output logic [31:0]       sram_datain,
   input  logic [31:0]       sram_dataout,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WRITE   = 3'd1,
      READ    = 3'd2,
      CAPTURE = 3'd3,
      RESP    = 3'd4
   } state_t;

   state_t          state;
   logic [1:0]      lane_q;
   logic [1:0]      size_q;
   logic [ROWS-1:0] wl_q;
   logic [3:0]      we_q;
   logic            re_q;
   logic [31:0]     din_q;
   logic [31:0]     rdata_q;
   logic            err_q;

   logic [1:0]      req_lane;
   logic            req_bad;
   logic [ROWS-1:0] req_wl;
   logic [3:0]      req_mask;
   logic [31:0]     req_din;
   logic [31:0]     rd_shift;
   logic [31:0]     rd_lane;

   assign req_lane = req_addr[1:0];
   assign req_wl   = ROWS'(1) << req_addr[ADDR_W-1:2];

   always_comb begin
      req_bad  = 1'b0;
      req_mask = 4'b1111;
      req_din  = req_wdata;
      case (req_size)
         2'b00: begin
            req_mask = 4'b0001 << req_lane;
            req_din  = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            req_bad  = req_lane[0];
            req_mask = 4'b0011 << req_lane;
            req_din  = {2{req_wdata[15:0]}};
         end
         2'b10:   req_bad = (req_lane != 2'b00);
         default: req_bad = 1'b1;
      endcase
   end

   // Move the addressed lane down to bit 0 before zero-extending.
   always_comb begin
      rd_shift = sram_dataout >> {lane_q, 3'b000};
      case (size_q)
         2'b00:   rd_lane = {24'b0, rd_shift[7:0]};
         2'b01:   rd_lane = {16'b0, rd_shift[15:0]};
         default: rd_lane = rd_shift;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         lane_q  <= 2'b00;
         size_q  <= 2'b00;
         wl_q    <= '0;
         we_q    <= 4'b0000;
         re_q    <= 1'b0;
         din_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lane_q  <= req_lane;
                  size_q  <= req_size;
                  rdata_q <= '0;
                  err_q   <= req_bad;
                  if (req_bad) begin
                     state <= RESP;
                  end else if (req_we) begin
                     state <= WRITE;
                     wl_q  <= req_wl;
                     we_q  <= req_mask;
                     din_q <= req_din;
                  end else begin
                     state <= READ;
                     wl_q  <= req_wl;
                     re_q  <= 1'b1;
                  end
               end
            end
            WRITE: begin
               state <= RESP;
               wl_q  <= '0;
               we_q  <= 4'b0000;
               din_q <= '0;
            end
            READ: state <= CAPTURE;
            CAPTURE: begin
               state   <= RESP;
               rdata_q <= rd_lane;
               wl_q    <= '0;
               re_q    <= 1'b0;
            end
            RESP: begin
               if (resp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Reset gates every output directly so a strobe cannot leak in the cycle rst rises.
   assign req_ready         = !rst && (state == IDLE);
   assign resp_valid        = !rst && (state == RESP);
   assign resp_rdata        = resp_valid ? rdata_q : '0;
   assign resp_err          = resp_valid && err_q;
   assign sram_wl           = rst ? '0 : wl_q;
   assign sram_write_enable = rst ? 4'b0000 : we_q;
   assign sram_read_enable  = !rst && re_q;
   assign sram_datain       = rst ? '0 : din_q;
   assign dbg_state         = state;

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomised bench for sram_ctrl: a transaction-level model predicts every output each cycle,
// and a behavioural SRAM array with a slow read path sits on the memory side.
module tb_sram_ctrl;
  localparam int ROWS   = 16;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_we;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid, resp_ready, resp_err;
  logic [31:0]       resp_rdata;
  logic [ROWS-1:0]   sram_wl;
  logic [3:0]        sram_write_enable;
  logic              sram_read_enable;
  logic [31:0]       sram_datain, sram_dataout;
  logic [2:0]        dbg_state;

  sram_ctrl #(.ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .sram_wl(sram_wl), .sram_write_enable(sram_write_enable), .sram_read_enable(sram_read_enable),
    .sram_datain(sram_datain), .sram_dataout(sram_dataout), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // reference model: memory image plus the transaction in flight
  logic [7:0]  ref_mem  [ROWS][4];
  logic [7:0]  sram_arr [ROWS][4];
  bit          m_active = 1'b0;
  int          m_cnt, m_lat;
  bit          m_we, m_err;
  logic [1:0]  m_size;
  logic [5:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;

  function automatic bit lane_hit(input logic [1:0] size, input logic [1:0] lane, input int k);
    if (size == 2'b00) return (k == int'(lane));
    if (size == 2'b01) return (k == int'(lane)) || (k == int'(lane) + 1);
    return 1'b1;
  endfunction

  function automatic bit is_bad(input logic [1:0] size, input logic [1:0] lane);
    if (size == 2'b11) return 1'b1;
    if (size == 2'b01) return lane[0];
    if (size == 2'b10) return lane != 2'b00;
    return 1'b0;
  endfunction

  always @(posedge clk) begin : model_p
    int row, ln, src;
    if (rst) begin
      m_active = 1'b0;
    end else if (m_active) begin
      row = int'(m_addr[5:2]);
      ln  = int'(m_addr[1:0]);
      if (m_we && !m_err && m_cnt == 1) begin
        for (int k = 0; k < 4; k++) begin
          if (lane_hit(m_size, m_addr[1:0], k)) begin
            src = (m_size == 2'b10) ? k : k - ln;
            ref_mem[row][k] = m_wdata[8*src +: 8];
          end
        end
      end
      if (m_cnt >= m_lat && resp_ready) m_active = 1'b0;
      else m_cnt++;
    end else if (req_valid) begin
      m_active = 1'b1;
      m_cnt    = 1;
      m_we     = req_we;
      m_size   = req_size;
      m_addr   = req_addr;
      m_wdata  = req_wdata;
      m_err    = is_bad(req_size, req_addr[1:0]);
      m_lat    = m_err ? 1 : (req_we ? 2 : 3);
      m_rdata  = '0;
      row = int'(req_addr[5:2]);
      ln  = int'(req_addr[1:0]);
      if (!m_err && !req_we) begin
        if (req_size == 2'b00) m_rdata = {24'b0, ref_mem[row][ln]};
        else if (req_size == 2'b01) m_rdata = {16'b0, ref_mem[row][ln+1], ref_mem[row][ln]};
        else m_rdata = {ref_mem[row][3], ref_mem[row][2], ref_mem[row][1], ref_mem[row][0]};
      end
    end
  end

  // compare process, then the SRAM array (writes mid-cycle, read data valid only from
  // the second consecutive read-enable cycle)
  bit re_prev = 1'b0;
  always @(negedge clk) begin : cmp_p
    logic            e_rr, e_rv, e_re;
    logic [ROWS-1:0] e_wl;
    logic [3:0]      e_we;
    logic [31:0]     e_din, rd;
    logic [54:0]     act_v, exp_v;
    e_rr = 0; e_rv = 0; e_re = 0; e_wl = '0; e_we = '0; e_din = '0;
    if (!rst) begin
      if (!m_active) e_rr = 1'b1;
      else if (m_cnt < m_lat) begin
        e_wl = 16'(1) << m_addr[5:2];
        if (m_we) begin
          for (int k = 0; k < 4; k++) e_we[k] = lane_hit(m_size, m_addr[1:0], k);
          if (m_size == 2'b00) e_din = {4{m_wdata[7:0]}};
          else if (m_size == 2'b01) e_din = {2{m_wdata[15:0]}};
          else e_din = m_wdata;
        end else e_re = 1'b1;
      end else e_rv = 1'b1;
    end
    act_v = {req_ready, resp_valid, sram_wl, sram_write_enable, sram_read_enable, sram_datain};
    exp_v = {e_rr, e_rv, e_wl, e_we, e_re, e_din};
    checks++;
    if (act_v === exp_v) passes++;
    else $display("FAIL cycle_outputs @%0t state=%0d: got %h expected %h", $time, dbg_state, act_v, exp_v);
    if (e_rv) check("resp_payload", {31'b0, resp_err, resp_rdata}, {31'b0, m_err, m_rdata});

    for (int r = 0; r < ROWS; r++)
      if (sram_wl[r])
        for (int k = 0; k < 4; k++)
          if (sram_write_enable[k]) sram_arr[r][k] = sram_datain[8*k +: 8];
    if (sram_read_enable && re_prev) begin
      rd = '0;
      for (int r = 0; r < ROWS; r++)
        if (sram_wl[r]) rd = rd | {sram_arr[r][3], sram_arr[r][2], sram_arr[r][1], sram_arr[r][0]};
      sram_dataout = rd;
    end else sram_dataout = $urandom;
    re_prev = sram_read_enable;
  end

  // driver tasks
  int              r_lat;
  logic [31:0]     r_rdata, r_last, s_din;
  logic            r_err, s_re;
  logic [ROWS-1:0] s_wl;
  logic [3:0]      s_we;

  task automatic scramble();
    req_valid = 1'($urandom_range(0, 1));
    req_we    = 1'($urandom_range(0, 1));
    req_size  = 2'($urandom_range(0, 3));
    req_addr  = 6'($urandom_range(0, 63));
    req_wdata = $urandom;
  endtask

  task automatic present(input logic we, input logic [1:0] size, input logic [5:0] addr,
                         input logic [31:0] wdata);
    int n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin checks++; $display("FAIL ready_timeout: got 0 expected 1"); end
    req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
  endtask

  task automatic txn(input logic we, input logic [1:0] size, input logic [5:0] addr,
                     input logic [31:0] wdata, input int hold);
    present(we, size, addr, wdata);
    s_wl = sram_wl; s_we = sram_write_enable; s_re = sram_read_enable; s_din = sram_datain;
    scramble();
    r_lat = 1;
    while (!resp_valid && r_lat < 8) begin @(posedge clk); #1; scramble(); r_lat++; end
    if (!resp_valid) begin
      checks++; $display("FAIL resp_timeout: got no response expected one");
      r_rdata = '0; r_err = 1'b0; r_last = '0; req_valid = 1'b0;
      return;
    end
    r_rdata = resp_rdata; r_err = resp_err;
    repeat (hold) begin @(posedge clk); #1; scramble(); end
    r_last = resp_rdata;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
  endtask

  task automatic abort_txn(input logic we, input logic [1:0] size, input logic [5:0] addr,
                           input logic [31:0] wdata, input int extra);
    present(we, size, addr, wdata);
    scramble();
    repeat (extra) begin @(posedge clk); #1; scramble(); end
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; scramble(); end
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("ready_after_abort", req_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] sz;
    logic [5:0] ad;
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < 4; k++) begin
        ref_mem[r][k]  = 8'($urandom);
        sram_arr[r][k] = ref_mem[r][k];
      end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_addr = '0;
    req_wdata = '0; resp_ready = 1'b0; sram_dataout = '0;
    repeat (3) @(posedge clk); #1;
    check("reset_req_ready", req_ready, 0);
    check("reset_resp_valid", resp_valid, 0);
    check("reset_strobes", {sram_wl, sram_write_enable, sram_read_enable}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", req_ready, 1);

    // word store / load
    txn(1'b1, 2'b10, 6'h08, 32'hDEADBEEF, 0);
    check("w_store_wl", s_wl, 16'h0004);
    check("w_store_we", s_we, 4'b1111);
    check("w_store_din", s_din, 32'hDEADBEEF);
    check("w_store_lat", r_lat, 2);
    txn(1'b0, 2'b10, 6'h08, 32'h0, 0);
    check("w_load_data", r_rdata, 32'hDEADBEEF);
    check("w_load_err", r_err, 0);
    check("w_load_lat", r_lat, 3);
    check("w_load_re", s_re, 1);

    // byte store into a known word
    txn(1'b1, 2'b10, 6'h0C, 32'h11223344, 1);
    txn(1'b1, 2'b00, 6'h0D, 32'h000000A5, 0);
    check("b_store_we", s_we, 4'b0010);
    check("b_store_din", s_din, 32'hA5A5A5A5);
    check("b_store_wl", s_wl, 16'h0008);
    txn(1'b0, 2'b00, 6'h0D, 32'h0, 0);
    check("b_load_data", r_rdata, 32'h000000A5);
    txn(1'b0, 2'b10, 6'h0C, 32'h0, 0);
    check("b_word_back", r_rdata, 32'h1122A544);
    txn(1'b0, 2'b01, 6'h0E, 32'h0, 0);
    check("h_load_data", r_rdata, 32'h00001122);

    // misaligned requests
    txn(1'b0, 2'b01, 6'h03, 32'h0, 0);
    check("mis_h_err", r_err, 1);
    check("mis_h_data", r_rdata, 0);
    check("mis_h_lat", r_lat, 1);
    check("mis_h_strobe", {s_wl, s_we, s_re}, 0);
    txn(1'b0, 2'b10, 6'h06, 32'h0, 0);
    check("mis_w_err", r_err, 1);
    check("mis_w_lat", r_lat, 1);
    txn(1'b1, 2'b11, 6'h00, 32'hFFFFFFFF, 0);
    check("bad_size_err", r_err, 1);

    // response held off
    txn(1'b0, 2'b10, 6'h08, 32'h0, 5);
    check("hold_first", r_rdata, 32'hDEADBEEF);
    check("hold_last", r_last, 32'hDEADBEEF);

    // reset aborts: load in CAPTURE, store in WRITE
    abort_txn(1'b0, 2'b10, 6'h08, 32'h0, 1);
    txn(1'b0, 2'b10, 6'h08, 32'h0, 0);
    check("load_after_abort", r_rdata, 32'hDEADBEEF);
    abort_txn(1'b1, 2'b10, 6'h08, 32'h0BADF00D, 0);
    txn(1'b0, 2'b10, 6'h08, 32'h0, 0);
    check("store_aborted", r_rdata, 32'hDEADBEEF);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom_range(0, 3));
      ad = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) ad[0] = 1'b0;
        if (sz == 2'b10) ad[1:0] = 2'b00;
      end
      if ($urandom_range(0, 39) == 0)
        abort_txn(1'($urandom_range(0, 1)), sz, ad, $urandom, $urandom_range(0, 1));
      else
        txn(1'($urandom_range(0, 1)), sz, ad, $urandom, $urandom_range(0, 2));
    end

    repeat (2) @(posedge clk);
    for (int r = 0; r < ROWS; r++)
      check("final_row", {sram_arr[r][3], sram_arr[r][2], sram_arr[r][1], sram_arr[r][0]},
            {ref_mem[r][3], ref_mem[r][2], ref_mem[r][1], ref_mem[r][0]});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter ROWS, default 16, number of 32-bit SRAM rows (word lines); power of two, >= 2.
REQ-002 Parameter ADDR_W, default $clog2(ROWS)+2, byte address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  initiator request present.
REQ-006 req_ready  output  1  controller can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 req_addr  input  ADDR_W  byte address; row = req_addr[ADDR_W-1:2], lane = req_addr[1:0].
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  initiator accepts response.
REQ-013 resp_rdata  output  32  load data, zero-extended; 0 for stores and errors.
REQ-014 resp_err  output  1  misaligned or illegal-size request.
REQ-015 sram_wl  output  ROWS  one-hot word line select to the byte array.
REQ-016 sram_write_enable  output  4  per-byte-lane write enable.
REQ-017 sram_read_enable  output  1  read enable, common to all lanes.
REQ-018 sram_datain  output  32  write data to the byte array, lane k = bits [8k+7:8k].
REQ-019 sram_dataout  input  32  read data from the byte array.

Function
REQ-020 FSM states SHALL be IDLE, WRITE, READ, CAPTURE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 A request SHALL be accepted when req_valid && req_ready; all request fields registered at acceptance, later input changes ignored.
REQ-022 Error: size 11, halfword with addr[0]=1, or word with addr[1:0]!=0 -> IDLE to RESP, no SRAM strobe, resp_err=1, resp_rdata=0.
REQ-023 Legal store: IDLE -> WRITE (one cycle) -> RESP.
REQ-024 In WRITE: sram_wl one-hot at row; sram_write_enable = 0001<<lane (byte), 0011<<lane (half), 1111 (word); sram_datain = byte replicated x4 / half replicated x2 / word.
REQ-025 Legal load: IDLE -> READ -> CAPTURE -> RESP.
REQ-026 In READ and CAPTURE: sram_wl one-hot at row, sram_read_enable=1, sram_write_enable=0; sram_dataout SHALL be sampled at the clock edge ending CAPTURE.
REQ-027 Load lane extraction: byte = dataout[8*lane+7:8*lane], half = dataout[8*lane+15:8*lane], word = all 32 bits; zero-extended to 32.
REQ-028 Outside WRITE/READ/CAPTURE: sram_wl, sram_write_enable, sram_read_enable SHALL be 0; sram_datain SHALL be 0.
REQ-029 Latency from acceptance edge N: error resp_valid at N+1, store at N+2, load at N+3.
REQ-030 In RESP: resp_valid=1, resp_rdata/resp_err held stable until resp_valid && resp_ready; next state IDLE.
REQ-031 No request accepted in the cycle the response is consumed; back-to-back requests are one IDLE cycle apart minimum.
REQ-032 Row index wraps naturally; no out-of-range row exists since ROWS is a power of two.

Reset
REQ-033 While rst=1 at a clock edge: state -> IDLE; req_ready, resp_valid, resp_err, resp_rdata, all sram_* outputs SHALL be 0 during rst-high cycles.
REQ-034 rst asserted mid-operation SHALL abort it with no response and no further SRAM strobe; an aborted WRITE cycle coinciding with rst SHALL not assert sram_write_enable.
REQ-035 First cycle after rst deasserts: IDLE, req_ready=1.

Verification
REQ-036 Word store addr 0x08 data 0xDEADBEEF, then word load 0x08 -> sram_wl=bit 2, write_enable=1111; load resp_rdata=0xDEADBEEF at N+3, resp_err=0.
REQ-037 Byte store 0xA5 to addr 0x0D -> write_enable=0010, sram_datain=0xA5A5A5A5; byte load 0x0D -> 0x000000A5; word load 0x0C -> only lane 1 changed.
REQ-038 Halfword load addr 0x03 and word load addr 0x06 -> resp_err=1, resp_rdata=0 at N+1, no sram strobe ever asserted.
REQ-039 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stable, req_ready=0, no SRAM activity; release -> IDLE next cycle.
REQ-040 Assert rst during CAPTURE of a load -> no resp_valid, all outputs 0, req_ready=1 the cycle after rst drops; subsequent load returns correct data.
